// File: rtl/llx_to_fifo36.sv
// llx_to_fifo36
//   Packs 8- or 16-bit LocalLink beats into 36-bit fifo36 words
//   {occ[1:0], eof, sof, data[31:0]}. The byte order inside the word is
//   selectable. Unused lanes of a short word are zero. Malformed framing
//   is recovered: beats outside a frame are dropped, and a frame cut
//   short by a new sof is closed off with pkt_err.
//
// Parameters
//   LL_BYTES    bytes per LL beat (1 or 2)
//   BIG_ENDIAN  1: first byte in data[31:24]; 0: first byte in data[7:0]
//
// Ports
//   clk, reset_n    clock, async active-low reset
//   clear           synchronous flush of accumulator and output register
//   ll_data         beat data; for 16-bit beats the first byte is [15:8]
//   ll_rem          on an eof beat: 1 = both bytes valid, 0 = first only
//   ll_sof_n        start of frame (active low)
//   ll_eof_n        end of frame (active low)
//   ll_src_rdy_n    beat valid (active low)
//   ll_dst_rdy_n    beat ready (active low)
//   f36_data        output word
//   f36_src_rdy_o   output word valid
//   f36_dst_rdy_i   downstream ready
//   pkt_err         one-cycle pulse when a frame is cut short by a sof
module llx_to_fifo36 #(
  parameter int LL_BYTES   = 1,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [8*LL_BYTES-1:0] ll_data,
  input  logic                  ll_rem,
  input  logic                  ll_sof_n,
  input  logic                  ll_eof_n,
  input  logic                  ll_src_rdy_n,
  output logic                  ll_dst_rdy_n,
  output logic [35:0]           f36_data,
  output logic                  f36_src_rdy_o,
  input  logic                  f36_dst_rdy_i,
  output logic                  pkt_err
);

  logic [31:0] r_acc;
  logic [1:0]  r_cnt;
  logic        r_in_pkt;
  logic        r_first;
  logic [35:0] r_out_data;
  logic        r_out_vld;
  logic        r_pkt_err;

  logic        w_vld;
  logic        w_sof;
  logic        w_eof;
  logic        w_live;
  logic        w_trunc;
  logic        w_restart;
  logic        w_split;
  logic        w_complete;
  logic        w_need_out;
  logic        w_out_free;
  logic        w_acc;
  logic        w_flush;
  logic [2:0]  w_nb;
  logic [2:0]  w_base;
  logic [2:0]  w_sum;
  logic [1:0]  w_occ;
  logic [1:0]  w_idx;
  logic [1:0]  w_lane;
  logic [31:0] w_word;

  assign w_vld = ~ll_src_rdy_n;
  assign w_sof = ~ll_sof_n;
  assign w_eof = ~ll_eof_n;

  assign w_nb = (LL_BYTES == 1 || (w_eof && !ll_rem)) ? 3'd1 : 3'd2;

  // A beat outside a frame without sof is dropped.
  assign w_live    = r_in_pkt | w_sof;
  assign w_trunc   = r_in_pkt & w_sof & (r_cnt != 2'd0);
  assign w_restart = r_in_pkt & w_sof & (r_cnt == 2'd0);
  // A truncating sof that is also an eof needs two words. The partial word
  // is flushed first while the beat is held. The beat is then taken on the
  // next cycle as an ordinary single-beat frame.
  assign w_split   = w_trunc & w_eof;

  assign w_base     = w_sof ? 3'd0 : {1'b0, r_cnt};
  assign w_sum      = w_base + w_nb;
  assign w_complete = w_live & (w_eof | (w_sum == 3'd4));
  assign w_occ      = w_eof ? w_sum[1:0] : 2'd0;

  assign w_need_out = w_vld & (w_trunc | w_complete);
  assign w_out_free = ~r_out_vld | f36_dst_rdy_i;

  assign ll_dst_rdy_n = w_vld & (w_split | (w_need_out & ~w_out_free));
  assign w_acc        = w_vld & ~ll_dst_rdy_n;
  assign w_flush      = w_vld & w_split & w_out_free;

  // Merge the incoming beat bytes into the accumulator image.
  always_comb begin
    w_word = w_sof ? 32'd0 : r_acc;
    w_idx  = 2'd0;
    w_lane = 2'd0;
    for (int b = 0; b < LL_BYTES; b++) begin
      if (3'(b) < w_nb) begin
        w_idx  = w_base[1:0] + 2'(b);
        w_lane = BIG_ENDIAN ? (2'd3 - w_idx) : w_idx;
        w_word[{w_lane, 3'b000} +: 8] = ll_data[8*(LL_BYTES-1-b) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= 32'd0;
      r_cnt      <= 2'd0;
      r_in_pkt   <= 1'b0;
      r_first    <= 1'b0;
      r_out_data <= 36'd0;
      r_out_vld  <= 1'b0;
      r_pkt_err  <= 1'b0;
    end else if (clear) begin
      r_acc      <= 32'd0;
      r_cnt      <= 2'd0;
      r_in_pkt   <= 1'b0;
      r_first    <= 1'b0;
      r_out_data <= 36'd0;
      r_out_vld  <= 1'b0;
      r_pkt_err  <= 1'b0;
    end else begin
      r_pkt_err <= 1'b0;
      if (r_out_vld && f36_dst_rdy_i)
        r_out_vld <= 1'b0;

      if (w_flush) begin
        r_out_data <= {r_cnt, 1'b1, r_first, r_acc};
        r_out_vld  <= 1'b1;
        r_acc      <= 32'd0;
        r_cnt      <= 2'd0;
        r_in_pkt   <= 1'b0;
        r_first    <= 1'b0;
        r_pkt_err  <= 1'b1;
      end else if (w_acc && w_live) begin
        r_pkt_err <= w_trunc | w_restart;
        // Close off the cut-short frame; the sof beat refills the accumulator.
        if (w_trunc) begin
          r_out_data <= {r_cnt, 1'b1, r_first, r_acc};
          r_out_vld  <= 1'b1;
        end
        if (w_complete) begin
          r_out_data <= {w_occ, w_eof, w_sof | r_first, w_word};
          r_out_vld  <= 1'b1;
          r_acc      <= 32'd0;
          r_cnt      <= 2'd0;
          r_first    <= 1'b0;
          r_in_pkt   <= ~w_eof;
        end else begin
          r_acc    <= w_word;
          r_cnt    <= w_sum[1:0];
          r_first  <= w_sof | r_first;
          r_in_pkt <= 1'b1;
        end
      end
    end
  end

  assign f36_data      = r_out_data;
  assign f36_src_rdy_o = r_out_vld;
  assign pkt_err       = r_pkt_err;

endmodule

// File: tb/tb_llx_to_fifo36.sv
module tb_llx_to_fifo36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic clear;

  logic [7:0]  s8_data;
  logic        s8_sof_n, s8_eof_n, s8_src_n, s8_dst, s8_rem;
  logic        o8_rdy_n, o8_vld, o8_err;
  logic [35:0] o8_data;

  logic [15:0] s16_data;
  logic        s16_sof_n, s16_eof_n, s16_src_n, s16_dst, s16_rem;
  logic        o16_rdy_n, o16_vld, o16_err;
  logic [35:0] o16_data;

  llx_to_fifo36 #(.LL_BYTES(1), .BIG_ENDIAN(1'b1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .ll_data(s8_data), .ll_rem(s8_rem), .ll_sof_n(s8_sof_n),
    .ll_eof_n(s8_eof_n), .ll_src_rdy_n(s8_src_n), .ll_dst_rdy_n(o8_rdy_n),
    .f36_data(o8_data), .f36_src_rdy_o(o8_vld), .f36_dst_rdy_i(s8_dst),
    .pkt_err(o8_err));

  llx_to_fifo36 #(.LL_BYTES(2), .BIG_ENDIAN(1'b0)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .ll_data(s16_data), .ll_rem(s16_rem), .ll_sof_n(s16_sof_n),
    .ll_eof_n(s16_eof_n), .ll_src_rdy_n(s16_src_n), .ll_dst_rdy_n(o16_rdy_n),
    .f36_data(o16_data), .f36_src_rdy_o(o16_vld), .f36_dst_rdy_i(s16_dst),
    .pkt_err(o16_err));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- 16-bit little-endian vector table ----------------
  typedef struct {
    logic        src_n, sof_n, eof_n, rem;
    logic [15:0] d;
    logic        dst;
    logic        e_rdy_n, e_vld, e_err;
    logic [35:0] e_data;
  } vec_t;

  function automatic vec_t mk(logic src_n, logic sof_n, logic eof_n, logic rem,
                              logic [15:0] d, logic dst, logic e_rdy_n,
                              logic e_vld, logic e_err, logic [35:0] e_data);
    vec_t v;
    v.src_n = src_n; v.sof_n = sof_n; v.eof_n = eof_n; v.rem = rem;
    v.d = d; v.dst = dst; v.e_rdy_n = e_rdy_n; v.e_vld = e_vld;
    v.e_err = e_err; v.e_data = e_data;
    return v;
  endfunction

  // ---------------- 8-bit big-endian scoreboard ----------------
  logic [35:0] exp_q[$];
  int          err_seen  = 0;
  int          err_exp   = 0;
  int          stall_cnt = 0;
  int          word_idx  = 0;
  int          dst_mode  = 0;
  logic        hold_prev = 1'b0;
  logic [35:0] prev_data = 36'd0;

  function automatic logic pick_dst();
    case (dst_mode)
      0:       return 1'b1;
      1:       return $urandom_range(0, 3) != 0;
      2:       return $urandom_range(0, 1) == 1;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle on the 8-bit DUT: drive at negedge, observe 1 time unit later.
  task automatic step8(input logic src_n, input logic sof_n, input logic eof_n,
                       input logic [7:0] d, input logic dst, output logic acc);
    logic [35:0] e;
    @(negedge clk);
    s8_src_n = src_n; s8_sof_n = sof_n; s8_eof_n = eof_n;
    s8_data = d; s8_dst = dst;
    #1;
    acc = ~src_n & ~o8_rdy_n;
    if (~src_n && !acc) stall_cnt++;
    if (o8_err) err_seen++;
    if (hold_prev) begin
      chk("hold_vld", {35'd0, o8_vld}, 36'd1);
      chk("hold_data", o8_data, prev_data);
    end
    hold_prev = o8_vld & ~dst;
    prev_data = o8_data;
    if (o8_vld && dst) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_word: got %h expected none", o8_data);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("word%0d", word_idx), o8_data, e);
      end
      word_idx++;
    end
  endtask

  task automatic send8(input logic sof_n, input logic eof_n, input logic [7:0] d);
    logic acc;
    for (int t = 0; t < 40; t++) begin
      step8(1'b0, sof_n, eof_n, d, pick_dst(), acc);
      if (acc) return;
    end
    n_chk++;
    $display("FAIL accept_timeout: beat %h not accepted within 40 cycles", d);
  endtask

  task automatic idle8(input int n);
    logic acc;
    repeat (n) step8(1'b1, 1'b1, 1'b1, 8'h00, pick_dst(), acc);
  endtask

  // Reference: a frame's bytes split into 4-byte words, big-endian lanes.
  task automatic model_frame(input logic [7:0] q[$], input logic term);
    int          n, nw;
    logic [31:0] d;
    logic        last, eof;
    logic [1:0]  occ;
    n  = q.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4*w + j < n) d[31-8*j -: 8] = q[4*w + j];
      last = (w == nw - 1);
      eof  = last && (term || (n % 4 != 0));
      occ  = eof ? 2'(n % 4) : 2'd0;
      exp_q.push_back({occ, eof, (w == 0), d});
    end
  endtask

  task automatic send_frame8(input logic [7:0] q[$], input logic term);
    for (int i = 0; i < q.size(); i++)
      send8(logic'(i != 0), logic'(!(term && i == q.size() - 1)), q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        tv[17];
    logic        acc;
    logic        trunc, prev_term;
    logic [7:0]  fq[$];
    int          n;

    tv[0]  = mk(1,1,1,0,16'h0000,1, 0,0,0,36'h0);
    tv[1]  = mk(0,0,1,0,16'hAABB,1, 0,0,0,36'h0);
    tv[2]  = mk(0,1,0,0,16'hCC55,1, 0,1,0,36'hF00CCBBAA);
    tv[3]  = mk(0,0,1,0,16'h0102,1, 0,0,0,36'h0);
    tv[4]  = mk(0,1,0,1,16'h0304,1, 0,1,0,36'h304030201);
    tv[5]  = mk(0,0,1,0,16'h1112,0, 0,1,0,36'h304030201);
    tv[6]  = mk(0,1,1,0,16'h1314,0, 1,1,0,36'h304030201);
    tv[7]  = mk(0,1,1,0,16'h1314,1, 0,1,0,36'h114131211);
    tv[8]  = mk(0,1,0,1,16'h1516,0, 1,1,0,36'h114131211);
    tv[9]  = mk(0,1,0,1,16'h1516,1, 0,1,0,36'hA00001615);
    tv[10] = mk(1,1,1,0,16'h0000,1, 0,0,0,36'h0);
    tv[11] = mk(0,0,1,0,16'h2122,1, 0,0,0,36'h0);
    tv[12] = mk(0,0,1,0,16'h3132,1, 0,1,1,36'hB00002221);
    tv[13] = mk(0,1,0,0,16'h3334,1, 0,1,0,36'hF00333231);
    tv[14] = mk(1,1,1,0,16'h0000,1, 0,0,0,36'h0);
    tv[15] = mk(0,1,1,0,16'h7777,1, 0,0,0,36'h0);
    tv[16] = mk(0,1,0,1,16'h8888,1, 0,0,0,36'h0);

    reset_n = 1'b0; clear = 1'b0;
    s8_src_n = 1; s8_sof_n = 1; s8_eof_n = 1; s8_data = 0; s8_dst = 1; s8_rem = 0;
    s16_src_n = 1; s16_sof_n = 1; s16_eof_n = 1; s16_data = 0; s16_dst = 1; s16_rem = 0;
    repeat (2) @(negedge clk);
    chk("rst8_vld",  {35'd0, o8_vld},   36'd0);
    chk("rst8_data", o8_data,           36'd0);
    chk("rst8_err",  {35'd0, o8_err},   36'd0);
    chk("rst8_rdy",  {35'd0, o8_rdy_n}, 36'd0);
    chk("rst16_vld", {35'd0, o16_vld},  36'd0);
    chk("rst16_data", o16_data,         36'd0);
    reset_n = 1'b1;

    // 16-bit little-endian table
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s16_src_n = tv[i].src_n; s16_sof_n = tv[i].sof_n; s16_eof_n = tv[i].eof_n;
      s16_rem = tv[i].rem; s16_data = tv[i].d; s16_dst = tv[i].dst;
      #1;
      chk($sformatf("v%0d_rdy_n", i), {35'd0, o16_rdy_n}, {35'd0, tv[i].e_rdy_n});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), {35'd0, o16_vld}, {35'd0, tv[i].e_vld});
      chk($sformatf("v%0d_err", i), {35'd0, o16_err}, {35'd0, tv[i].e_err});
      if (tv[i].e_vld) chk($sformatf("v%0d_data", i), o16_data, tv[i].e_data);
    end
    @(negedge clk);
    s16_src_n = 1; s16_sof_n = 1; s16_eof_n = 1; s16_data = 0; s16_dst = 1;

    // 5-byte frame at full rate
    dst_mode = 0;
    exp_q.push_back(36'h111121314);
    exp_q.push_back(36'h615000000);
    stall_cnt = 0;
    send8(0, 1, 8'h11); send8(1, 1, 8'h12); send8(1, 1, 8'h13);
    send8(1, 1, 8'h14); send8(1, 0, 8'h15);
    idle8(2);
    chk("five_byte_nostall", 36'(stall_cnt), 36'd0);

    // sof-less beats dropped, then a single-beat frame
    send8(1, 1, 8'h01); send8(1, 1, 8'h02);
    exp_q.push_back(36'h77E000000);
    send8(0, 0, 8'h7E);
    idle8(2);

    // Truncation by a new sof
    exp_q.push_back(36'hBAAAB0000);
    exp_q.push_back(36'hB55560000);
    err_exp++;
    send8(0, 1, 8'hAA); send8(1, 1, 8'hAB);
    send8(0, 1, 8'h55);
    idle8(1);
    chk("trunc_err_hi", {35'd0, o8_err}, 36'd1);
    idle8(1);
    chk("trunc_err_lo", {35'd0, o8_err}, 36'd0);
    send8(1, 0, 8'h56);
    idle8(2);

    // 9-byte frame with downstream held: stall only at byte 8
    exp_q.push_back(36'h121222324);
    exp_q.push_back(36'h025262728);
    exp_q.push_back(36'h629000000);
    dst_mode  = 3;
    stall_cnt = 0;
    send8(0, 1, 8'h21);
    for (int b = 2; b <= 7; b++) send8(1, 1, 8'(8'h20 + b));
    chk("nine_byte_no_early_stall", 36'(stall_cnt), 36'd0);
    for (int k = 0; k < 3; k++) begin
      step8(1'b0, 1'b1, 1'b1, 8'h28, 1'b0, acc);
      chk($sformatf("byte8_stall%0d", k), {35'd0, acc}, 36'd0);
    end
    dst_mode = 0;
    send8(1, 1, 8'h28);
    send8(1, 0, 8'h29);
    idle8(3);

    // clear discards a held word and the partial frame
    dst_mode = 3;
    send8(0, 1, 8'h41); send8(1, 1, 8'h42); send8(1, 1, 8'h43); send8(1, 1, 8'h44);
    idle8(1);
    @(negedge clk);
    s8_src_n = 1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    hold_prev = 1'b0;
    #1;
    chk("clear_vld",  {35'd0, o8_vld}, 36'd0);
    chk("clear_data", o8_data,         36'd0);
    dst_mode = 0;
    exp_q.push_back(36'h745000000);
    send8(0, 0, 8'h45);
    idle8(2);

    // Asynchronous reset mid-word
    send8(0, 1, 8'h01); send8(1, 1, 8'h02);
    @(negedge clk);
    s8_src_n = 1; s8_sof_n = 1; s8_eof_n = 1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_vld",  {35'd0, o8_vld},   36'd0);
    chk("arst_data", o8_data,           36'd0);
    chk("arst_err",  {35'd0, o8_err},   36'd0);
    chk("arst_rdy",  {35'd0, o8_rdy_n}, 36'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hold_prev = 1'b0;
    exp_q.push_back(36'hB31320000);
    send8(0, 1, 8'h31); send8(1, 0, 8'h32);
    idle8(2);

    // Randomized frames against the byte-chunking model
    prev_term = 1'b1;
    for (int f = 0; f < 80; f++) begin
      dst_mode = (f < 40) ? 1 : 2;
      if (prev_term && $urandom_range(0, 4) == 0)
        send8(1, logic'($urandom_range(0, 1)), 8'($urandom));
      n = $urandom_range(1, 11);
      fq.delete();
      repeat (n) fq.push_back(8'($urandom));
      trunc = (f < 79) && ($urandom_range(0, 5) == 0);
      model_frame(fq, !trunc);
      if (trunc) err_exp++;
      send_frame8(fq, !trunc);
      prev_term = !trunc;
      idle8($urandom_range(0, 2));
    end
    dst_mode = 0;
    idle8(10);
    chk("leftover_words", 36'(exp_q.size()), 36'd0);
    chk("pkt_err_count",  36'(err_seen),     36'(err_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
